// File: rtl/obstacle_scroller_if.sv
// Signal bundle between the game FSM / renderer side (master) and the
// obstacle scroller (slave).
interface obstacle_scroller_if #(
  parameter int NUM_PIPES = 3,
  parameter int XW        = 11
);
  logic [2:0]              status;
  logic                    pause;
  logic [2:0]              pipe_cnt;
  logic [NUM_PIPES-1:0]    pipe_valid;
  logic [NUM_PIPES*XW-1:0] oxbuf;
  logic [NUM_PIPES*XW-1:0] oybuf;
  logic                    pass_pulse;
  logic [15:0]             score;
  logic [3:0]              cur_shift;

  modport master (
    output status, pause,
    input  pipe_cnt, pipe_valid, oxbuf, oybuf, pass_pulse, score, cur_shift
  );

  modport slave (
    input  status, pause,
    output pipe_cnt, pipe_valid, oxbuf, oybuf, pass_pulse, score, cur_shift
  );
endinterface

// File: rtl/obstacle_scroller.sv
// Scrolling pipe queue: spawns at the right edge, scrolls left each frame tick,
// retires off-screen pipes, counts passes. Define DIFFICULTY_RAMP_EN for speed ramp.
module obstacle_scroller #(
  parameter int NUM_PIPES  = 3,
  parameter int XW         = 11,
  parameter int SCREEN_W   = 640,
  parameter int SPACING    = 250,
  parameter int PIPE_W     = 70,
  parameter int PASS_X     = 90,
  parameter int SHIFT      = 4,
  parameter int SHIFT_MAX  = 8,
  parameter int RAMP_EVERY = 5,
  parameter int GAP_MIN    = 100,
  parameter int GAP_STEP   = 20,
  parameter int GAP_LEVELS = 9
) (
  input  logic               clock_div,
  input  logic               reset,
  obstacle_scroller_if.slave bus
);

  localparam logic signed [XW-1:0] X_ZERO      = '0;
  localparam logic signed [XW-1:0] SPAWN_X     = XW'(SCREEN_W);
  localparam logic signed [XW-1:0] SPAWN_LIMIT = XW'(SCREEN_W - SPACING);
  localparam logic signed [XW-1:0] PIPE_W_S    = XW'(PIPE_W);
  localparam logic signed [XW-1:0] PASS_X_S    = XW'(PASS_X);
  localparam logic [2:0]           MAX_CNT     = 3'(NUM_PIPES);
  localparam logic [7:0]           LFSR_SEED   = 8'hB5;
  localparam logic signed [XW-1:0] GAP_SEED    =
    XW'(GAP_MIN + (int'(LFSR_SEED) % GAP_LEVELS) * GAP_STEP);
  // An inconsistent speed configuration falls back to a 1-pixel step so it shows on screen.
  localparam bit CFG_OK = (NUM_PIPES >= 1) && (NUM_PIPES <= 7) && (SHIFT <= SHIFT_MAX) &&
                          (SHIFT_MAX <= 15) && (RAMP_EVERY >= 1);
  localparam logic [3:0] SHIFT_INIT = CFG_OK ? 4'(SHIFT) : 4'd1;

  logic [7:0]           r_lfsr;
  logic signed [XW-1:0] r_rand_pos;
  logic signed [XW-1:0] r_x [NUM_PIPES];
  logic signed [XW-1:0] r_y [NUM_PIPES];
  logic [NUM_PIPES-1:0] r_valid;
  logic [2:0]           r_cnt;
  logic                 r_pass;
  logic [15:0]          r_score;
  logic [3:0]           r_shift;
`ifdef DIFFICULTY_RAMP_EN
  localparam logic [3:0]  SHIFT_CEIL = 4'(SHIFT_MAX);
  localparam logic [15:0] RAMP_LAST  = 16'(RAMP_EVERY - 1);
  logic [15:0]          r_ramp_cnt;
`endif

  logic signed [XW-1:0] w_gap;
  logic signed [XW-1:0] w_step;
  logic signed [XW-1:0] w_x0_moved;
  logic signed [XW-1:0] w_last_x;
  logic                 w_retire;
  logic                 w_spawn;
  logic                 w_pass;
  logic [2:0]           w_spawn_idx;
  logic [2:0]           w_cnt_next;
  logic signed [XW-1:0] w_x_next [NUM_PIPES];
  logic signed [XW-1:0] w_y_next [NUM_PIPES];
  logic [NUM_PIPES-1:0] w_valid_next;

  assign w_gap      = XW'(GAP_MIN + (int'(r_lfsr) % GAP_LEVELS) * GAP_STEP);
  assign w_step     = signed'({{(XW-4){1'b0}}, r_shift});
  assign w_x0_moved = r_x[0] - w_step;

  always_comb begin
    w_last_x = X_ZERO;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (r_cnt == 3'(i + 1)) w_last_x = r_x[i];
    end
  end

  // All decisions look at the pre-move registered positions.
  assign w_retire    = r_valid[0] && ((r_x[0] + PIPE_W_S) <= X_ZERO);
  assign w_spawn     = (r_cnt == 3'd0) || ((r_cnt < MAX_CNT) && (w_last_x < SPAWN_LIMIT));
  assign w_pass      = r_valid[0] && (r_x[0] >= PASS_X_S) && (w_x0_moved < PASS_X_S);
  assign w_spawn_idx = w_retire ? (r_cnt - 3'd1) : r_cnt;
  assign w_cnt_next  = r_cnt + {2'b00, w_spawn} - {2'b00, w_retire};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIPES; gi++) begin : g_slot
      logic signed [XW-1:0] w_src_x;
      logic signed [XW-1:0] w_src_y;
      logic                 w_src_v;
      logic                 w_take_new;

      if (gi == NUM_PIPES - 1) begin : g_top
        assign w_src_x = w_retire ? X_ZERO : r_x[gi];
        assign w_src_y = w_retire ? X_ZERO : r_y[gi];
        assign w_src_v = w_retire ? 1'b0   : r_valid[gi];
      end else begin : g_mid
        assign w_src_x = w_retire ? r_x[gi+1]     : r_x[gi];
        assign w_src_y = w_retire ? r_y[gi+1]     : r_y[gi];
        assign w_src_v = w_retire ? r_valid[gi+1] : r_valid[gi];
      end

      assign w_take_new       = w_spawn && (w_spawn_idx == 3'(gi));
      assign w_valid_next[gi] = w_take_new | w_src_v;
      assign w_x_next[gi]     = w_take_new ? SPAWN_X :
                                (w_src_v ? (w_src_x - w_step) : X_ZERO);
      assign w_y_next[gi]     = w_take_new ? r_rand_pos : (w_src_v ? w_src_y : X_ZERO);

      assign bus.oxbuf[gi*XW +: XW] = r_x[gi];
      assign bus.oybuf[gi*XW +: XW] = r_y[gi];
    end
  endgenerate

  always_ff @(posedge clock_div or negedge reset) begin
    if (!reset) begin
      r_lfsr     <= LFSR_SEED;
      r_rand_pos <= GAP_SEED;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_x[i] <= X_ZERO;
        r_y[i] <= X_ZERO;
      end
      r_valid    <= '0;
      r_cnt      <= 3'd0;
      r_pass     <= 1'b0;
      r_score    <= 16'd0;
      r_shift    <= SHIFT_INIT;
`ifdef DIFFICULTY_RAMP_EN
      r_ramp_cnt <= 16'd0;
`endif
    end else begin
      r_lfsr     <= {r_lfsr[3] ^ r_lfsr[5], r_lfsr[7:1]};
      r_rand_pos <= w_gap;
      r_pass     <= 1'b0;
      if (bus.status == 3'd2) begin
        if (!bus.pause) begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            r_x[i] <= w_x_next[i];
            r_y[i] <= w_y_next[i];
          end
          r_valid <= w_valid_next;
          r_cnt   <= w_cnt_next;
          if (w_pass) begin
            r_pass <= 1'b1;
            if (r_score != 16'hFFFF) begin
              r_score <= r_score + 16'd1;
`ifdef DIFFICULTY_RAMP_EN
              // The counter tracks score modulo RAMP_EVERY so no divider is needed.
              if (r_ramp_cnt == RAMP_LAST) begin
                r_ramp_cnt <= 16'd0;
                if (r_shift < SHIFT_CEIL) r_shift <= r_shift + 4'd1;
              end else begin
                r_ramp_cnt <= r_ramp_cnt + 16'd1;
              end
`endif
            end
          end
        end
      end else begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          r_x[i] <= X_ZERO;
          r_y[i] <= X_ZERO;
        end
        r_valid <= '0;
        r_cnt   <= 3'd0;
        r_shift <= SHIFT_INIT;
        if (bus.status == 3'd0) begin
          r_score    <= 16'd0;
`ifdef DIFFICULTY_RAMP_EN
          r_ramp_cnt <= 16'd0;
`endif
        end
      end
    end
  end

  assign bus.pipe_cnt   = r_cnt;
  assign bus.pipe_valid = r_valid;
  assign bus.pass_pulse = r_pass;
  assign bus.score      = r_score;
  assign bus.cur_shift  = r_shift;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Self-checking bench for obstacle_scroller: queue-based reference model,
// directed game milestones plus randomized status/pause traffic.
module tb_obstacle_scroller;
  localparam int NP = 3, XW = 11, SCREEN_W = 640, SPACING = 250, PIPE_W = 70;
  localparam int PASS_X = 90, SHIFT = 4, SHIFT_MAX = 8, RAMP_EVERY = 5;
  localparam int GAP_MIN = 100, GAP_STEP = 20, GAP_LEVELS = 9;
  localparam int AW = 3 + NP + 2*NP*XW + 1 + 16 + 4;
`ifdef DIFFICULTY_RAMP_EN
  localparam bit RAMP = 1'b1;
  localparam int EXP_SHIFT5 = 5, EXP_SHIFT20 = 8;
`else
  localparam bit RAMP = 1'b0;
  localparam int EXP_SHIFT5 = 4, EXP_SHIFT20 = 4;
`endif

  logic clock_div = 1'b0;
  logic reset = 1'b0;
  always #5 clock_div = ~clock_div;

  obstacle_scroller_if #(.NUM_PIPES(NP), .XW(XW)) bus();

  obstacle_scroller #(
    .NUM_PIPES(NP), .XW(XW), .SCREEN_W(SCREEN_W), .SPACING(SPACING), .PIPE_W(PIPE_W),
    .PASS_X(PASS_X), .SHIFT(SHIFT), .SHIFT_MAX(SHIFT_MAX), .RAMP_EVERY(RAMP_EVERY),
    .GAP_MIN(GAP_MIN), .GAP_STEP(GAP_STEP), .GAP_LEVELS(GAP_LEVELS)
  ) dut (
    .clock_div(clock_div),
    .reset(reset),
    .bus(bus)
  );

  int n_vec = 0;
  int n_miss = 0;

  // Reference model: pipes as an ordered queue, oldest first.
  int qx[$];
  int qy[$];
  int m_score, m_shift, m_rpos;
  bit m_pass;
  logic [7:0] m_lfsr;

  task automatic model_reset();
    qx.delete();
    qy.delete();
    m_score = 0;
    m_shift = SHIFT;
    m_pass  = 1'b0;
    m_lfsr  = 8'hB5;
    m_rpos  = GAP_MIN + (m_lfsr % GAP_LEVELS) * GAP_STEP;
  endtask

  task automatic model_tick(input logic [2:0] st, input logic pz);
    int  n;
    bit  ret, spn, pas;
    n = qx.size();
    m_pass = 1'b0;
    if (st == 3'd2 && !pz) begin
      ret = (n > 0) && (qx[0] + PIPE_W <= 0);
      spn = (n == 0) || ((n < NP) && (qx[n-1] < SCREEN_W - SPACING));
      pas = (n > 0) && (qx[0] >= PASS_X) && (qx[0] - m_shift < PASS_X);
      foreach (qx[i]) qx[i] = qx[i] - m_shift;
      if (ret) begin
        void'(qx.pop_front());
        void'(qy.pop_front());
      end
      if (spn) begin
        qx.push_back(SCREEN_W);
        qy.push_back(m_rpos);
      end
      if (pas) begin
        m_pass = 1'b1;
        if (m_score < 65535) begin
          m_score++;
          if (RAMP && (m_score % RAMP_EVERY == 0) && (m_shift < SHIFT_MAX)) m_shift++;
        end
      end
    end else if (st != 3'd2) begin
      qx.delete();
      qy.delete();
      m_shift = SHIFT;
      if (st == 3'd0) m_score = 0;
    end
    m_rpos = GAP_MIN + (m_lfsr % GAP_LEVELS) * GAP_STEP;
    m_lfsr = {m_lfsr[3] ^ m_lfsr[5], m_lfsr[7:1]};
  endtask

  function automatic logic [NP*XW-1:0] exp_xbuf();
    logic [NP*XW-1:0] v = '0;
    for (int i = 0; i < qx.size(); i++) v[i*XW +: XW] = XW'(qx[i]);
    return v;
  endfunction

  function automatic logic [AW-1:0] exp_all();
    logic [NP*XW-1:0] yv = '0;
    logic [NP-1:0]    vv = '0;
    for (int i = 0; i < qy.size(); i++) begin
      yv[i*XW +: XW] = XW'(qy[i]);
      vv[i] = 1'b1;
    end
    return {3'(qx.size()), vv, exp_xbuf(), yv, m_pass, 16'(m_score), 4'(m_shift)};
  endfunction

  function automatic logic [AW-1:0] dut_all();
    return {bus.pipe_cnt, bus.pipe_valid, bus.oxbuf, bus.oybuf,
            bus.pass_pulse, bus.score, bus.cur_shift};
  endfunction

  function automatic int dut_x(input int i);
    logic signed [XW-1:0] v;
    v = bus.oxbuf[i*XW +: XW];
    return int'(v);
  endfunction

  // One frame tick with whatever status/pause is currently driven; ends on a negedge.
  task automatic clk_step();
    @(posedge clock_div);
    model_tick(bus.status, bus.pause);
    @(negedge clock_div);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.status = 3'd0;
    bus.pause  = 1'b0;
    repeat (3) @(negedge clock_div);
    model_reset();
    n_vec++;
    if (dut_all() !== exp_all()) begin
      n_miss++;
      $display("FAIL reset_state got=%h exp=%h", dut_all(), exp_all());
    end
    n_vec++;
    if (bus.cur_shift !== 4'(SHIFT)) begin
      n_miss++;
      $display("FAIL reset_shift got=%0d exp=%0d", bus.cur_shift, SHIFT);
    end
    reset = 1'b1;
    $display("reset: released, cnt=%0d shift=%0d", bus.pipe_cnt, bus.cur_shift);
  endtask

  task automatic test_first_spawn();
    int gy;
    bus.status = 3'd2;
    clk_step();
    gy = int'(bus.oybuf[XW-1:0]);
    n_vec++;
    if (bus.pipe_cnt !== 3'd1 || dut_x(0) !== SCREEN_W) begin
      n_miss++;
      $display("FAIL first_spawn got cnt=%0d x0=%0d exp cnt=1 x0=%0d", bus.pipe_cnt, dut_x(0), SCREEN_W);
    end
    n_vec++;
    if (gy < GAP_MIN || gy > GAP_MIN + (GAP_LEVELS-1)*GAP_STEP || (gy - GAP_MIN) % GAP_STEP != 0) begin
      n_miss++;
      $display("FAIL first_gap_range got=%0d exp in 100..260 step 20", gy);
    end
    n_vec++;
    if (dut_all() !== exp_all()) begin
      n_miss++;
      $display("FAIL first_state got=%h exp=%h", dut_all(), exp_all());
    end
    $display("tick 1: cnt=%0d x0=%0d y0=%0d", bus.pipe_cnt, dut_x(0), gy);
  endtask

  task automatic test_scroll();
    repeat (64) clk_step();
    n_vec++;
    if (bus.pipe_cnt !== 3'd2 || dut_x(0) !== 384 || dut_x(1) !== 640) begin
      n_miss++;
      $display("FAIL scroll_65 got cnt=%0d x0=%0d x1=%0d exp cnt=2 x0=384 x1=640",
               bus.pipe_cnt, dut_x(0), dut_x(1));
    end
    n_vec++;
    if (dut_all() !== exp_all()) begin
      n_miss++;
      $display("FAIL scroll_state got=%h exp=%h", dut_all(), exp_all());
    end
    $display("tick 65: cnt=%0d x0=%0d x1=%0d", bus.pipe_cnt, dut_x(0), dut_x(1));
  endtask

  task automatic test_pass();
    repeat (73) clk_step();
    n_vec++;
    if (bus.pass_pulse !== 1'b0 || bus.score !== 16'd0) begin
      n_miss++;
      $display("FAIL pre_pass got pulse=%0b score=%0d exp pulse=0 score=0", bus.pass_pulse, bus.score);
    end
    clk_step();
    n_vec++;
    if (dut_x(0) !== 88 || bus.pass_pulse !== 1'b1 || bus.score !== 16'd1) begin
      n_miss++;
      $display("FAIL pass_139 got x0=%0d pulse=%0b score=%0d exp x0=88 pulse=1 score=1",
               dut_x(0), bus.pass_pulse, bus.score);
    end
    clk_step();
    n_vec++;
    if (bus.pass_pulse !== 1'b0 || bus.score !== 16'd1) begin
      n_miss++;
      $display("FAIL pass_width got pulse=%0b score=%0d exp pulse=0 score=1", bus.pass_pulse, bus.score);
    end
    $display("tick 139: pass seen, score=%0d", bus.score);
  endtask

  task automatic test_retire();
    repeat (39) clk_step();
    n_vec++;
    if (dut_x(0) !== -72 || bus.pipe_cnt !== 3'd3) begin
      n_miss++;
      $display("FAIL pre_retire got x0=%0d cnt=%0d exp x0=-72 cnt=3", dut_x(0), bus.pipe_cnt);
    end
    clk_step();
    n_vec++;
    if (dut_x(0) !== 180 || bus.pipe_cnt !== 3'd2) begin
      n_miss++;
      $display("FAIL retire got x0=%0d cnt=%0d exp x0=180 cnt=2", dut_x(0), bus.pipe_cnt);
    end
    $display("tick 180: retired, x0=%0d cnt=%0d", dut_x(0), bus.pipe_cnt);
    for (int t = 0; t < 400; t++) begin
      clk_step();
      n_vec++;
      if (dut_all() !== exp_all() || bus.pipe_cnt > 3'(NP)) begin
        n_miss++;
        $display("FAIL retire_run t=%0d got=%h exp=%h", t, dut_all(), exp_all());
      end
    end
  endtask

  task automatic test_pause();
    logic [NP*XW-1:0] sx;
    int ss;
    sx = exp_xbuf();
    ss = m_score;
    bus.pause = 1'b1;
    for (int t = 0; t < 20; t++) begin
      clk_step();
      n_vec++;
      if (bus.oxbuf !== sx || bus.score !== 16'(ss) || bus.pass_pulse !== 1'b0) begin
        n_miss++;
        $display("FAIL pause t=%0d got x=%h score=%0d pulse=%0b exp x=%h score=%0d pulse=0",
                 t, bus.oxbuf, bus.score, bus.pass_pulse, sx, ss);
      end
    end
    bus.pause = 1'b0;
    $display("pause: 20 ticks held, score=%0d", bus.score);
  endtask

  task automatic test_status();
    int ss;
    ss = m_score;
    bus.status = 3'd3;
    clk_step();
    n_vec++;
    if (bus.pipe_cnt !== 3'd0 || bus.pipe_valid !== '0 || bus.oxbuf !== '0 ||
        bus.oybuf !== '0 || bus.score !== 16'(ss) || ss == 0) begin
      n_miss++;
      $display("FAIL status3 got cnt=%0d x=%h y=%h score=%0d exp cnt=0 x=0 y=0 score=%0d (nonzero)",
               bus.pipe_cnt, bus.oxbuf, bus.oybuf, bus.score, ss);
    end
    bus.status = 3'd0;
    clk_step();
    n_vec++;
    if (bus.score !== 16'd0 || bus.cur_shift !== 4'(SHIFT)) begin
      n_miss++;
      $display("FAIL status0 got score=%0d shift=%0d exp score=0 shift=%0d", bus.score, bus.cur_shift, SHIFT);
    end
    $display("status: cleared by 3 (score kept %0d), score cleared by 0", ss);
  endtask

  task automatic test_random();
    int passes = 0;
    for (int t = 0; t < 2500; t++) begin
      bus.status = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      bus.pause  = ($urandom_range(0, 9) == 0);
      clk_step();
      n_vec++;
      if (dut_all() !== exp_all()) begin
        n_miss++;
        $display("FAIL random t=%0d got=%h exp=%h", t, dut_all(), exp_all());
      end
      if (m_pass) passes++;
    end
    bus.pause = 1'b0;
    $display("random: 2500 ticks, %0d passes, score=%0d", passes, m_score);
  endtask

  task automatic test_ramp();
    bit done = 1'b0;
    bus.status = 3'd0;
    clk_step();
    bus.status = 3'd2;
    for (int t = 0; t < 3000 && !done; t++) begin
      clk_step();
      n_vec++;
      if (dut_all() !== exp_all()) begin
        n_miss++;
        $display("FAIL ramp_run t=%0d got=%h exp=%h", t, dut_all(), exp_all());
      end
      if (m_pass && m_score == 5) begin
        n_vec++;
        if (bus.cur_shift !== 4'(EXP_SHIFT5)) begin
          n_miss++;
          $display("FAIL ramp5 got=%0d exp=%0d", bus.cur_shift, EXP_SHIFT5);
        end
      end
      if (m_pass && m_score == 20) begin
        n_vec++;
        if (bus.cur_shift !== 4'(EXP_SHIFT20)) begin
          n_miss++;
          $display("FAIL ramp20 got=%0d exp=%0d", bus.cur_shift, EXP_SHIFT20);
        end
      end
      if (m_score >= 21) done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_miss++;
      $display("FAIL ramp_timeout got score=%0d exp >= 21 within 3000 ticks", m_score);
    end
    $display("ramp: score=%0d cur_shift=%0d", bus.score, bus.cur_shift);
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (dut_all() !== exp_all()) begin
      n_miss++;
      $display("FAIL async_reset got=%h exp=%h", dut_all(), exp_all());
    end
    @(negedge clock_div);
    reset = 1'b1;
    $display("async reset: outputs cleared between edges");
  endtask

  initial begin
    bus.status = 3'd0;
    bus.pause  = 1'b0;
    test_reset();
    test_first_spawn();
    test_scroll();
    test_pass();
    test_retire();
    test_pause();
    test_status();
    test_random();
    test_ramp();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
